// File: rtl/pb_port_responder.sv
// pb_port_responder: I/O port responder for a small soft processor.
// Provides synchronized field inputs with change interrupt, a general
// output register, and a write-only output FIFO drained via valid/ready.
module pb_port_responder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    input  logic [1:0] input_a,
    input  logic [1:0] input_b,
    input  logic [1:0] input_c,
    input  logic [1:0] input_d,
    output logic [7:0] out,
    output logic       interrupt,
    input  logic       interrupt_ack,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Reads are decoded purely from port_id, so the strobe carries no state.
    logic unused_read_strobe;
    assign unused_read_strobe = read_strobe;

    logic [7:0]    sync_p0;
    logic [7:0]    sync_p1;
    logic [7:0]    hist_p2;
    logic          irq_en;
    logic          irq_pending;
    logic          overflow;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          wr_out;
    logic          wr_status;
    logic          wr_irq_en;
    logic          ovf_set;
    logic          irq_set;
    logic [7:0]    rd_data;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign wr_out    = write_strobe && (port_id == 8'h05);
    assign push_req  = write_strobe && (port_id == 8'h06);
    assign wr_status = write_strobe && (port_id == 8'h07);
    assign wr_irq_en = write_strobe && (port_id == 8'h08);

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign pop     = !empty && tx_ready;
    assign push    = push_req && (!full || pop);
    assign ovf_set = push_req && full && !pop;
    assign irq_set = irq_en && (sync_p1 != hist_p2);

    assign tx_valid  = !empty;
    assign tx_data   = mem[rd_ptr];
    assign interrupt = irq_pending;

    // Read mux sampled into in_port every cycle, regardless of read_strobe.
    always_comb begin
        rd_data = 8'h00;
        case (port_id)
            8'h01:   rd_data = {6'b0, sync_p1[1:0]};
            8'h02:   rd_data = {6'b0, sync_p1[3:2]};
            8'h03:   rd_data = {6'b0, sync_p1[5:4]};
            8'h04:   rd_data = {6'b0, sync_p1[7:6]};
            8'h07:   rd_data = {4'b0, irq_pending, overflow, full, empty};
            8'h08:   rd_data = {7'b0, irq_en};
            8'h09:   rd_data = 8'(count);
            default: rd_data = 8'h00;
        endcase
    end

    // Two-flop synchronizer plus previous-value history for change detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 8'h00;
            sync_p1 <= 8'h00;
            hist_p2 <= 8'h00;
        end else begin
            sync_p0 <= {input_d, input_c, input_b, input_a};
            sync_p1 <= sync_p0;
            hist_p2 <= sync_p1;
        end
    end

    // Processor-visible registers: read data, output, enables and sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_port     <= 8'h00;
            out         <= 8'h00;
            irq_en      <= 1'b0;
            overflow    <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            in_port <= rd_data;
            if (wr_out)    out    <= out_port;
            if (wr_irq_en) irq_en <= out_port[0];
            if (ovf_set)
                overflow <= 1'b1;
            else if (wr_status && out_port[2])
                overflow <= 1'b0;
            if (irq_set)
                irq_pending <= 1'b1;
            else if (interrupt_ack)
                irq_pending <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage holds data only; emptiness is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= out_port;
    end

endmodule

// File: tb/tb_pb_port_responder.sv
// tb_pb_port_responder: scenario tasks with a data scoreboard for the FIFO.
module tb_pb_port_responder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       write_strobe = 1'b0;
    logic       read_strobe = 1'b0;
    logic [7:0] in_port;
    logic [1:0] input_a = 2'b00;
    logic [1:0] input_b = 2'b00;
    logic [1:0] input_c = 2'b00;
    logic [1:0] input_d = 2'b00;
    logic [7:0] out;
    logic       interrupt;
    logic       interrupt_ack = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    pb_port_responder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
        .input_a(input_a), .input_b(input_b), .input_c(input_c), .input_d(input_d),
        .out(out), .interrupt(interrupt), .interrupt_ack(interrupt_ack),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        port_id = p; out_port = d; write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0; port_id = 8'h00;
    endtask

    task automatic rd(input logic [7:0] p, output logic [7:0] v);
        port_id = p; read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        v = in_port;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        tick(); tick();
        checks++; if (out !== 8'h00) begin failures++; $display("FAIL reset_out got=%h want=00", out); end
        checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL reset_in_port got=%h want=00", in_port); end
        checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL reset_interrupt got=%b want=0", interrupt); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
        rst = 1'b1;
        rd(8'h07, v);
        checks++; if (v !== 8'h01) begin failures++; $display("FAIL reset_status got=%h want=01", v); end
        rd(8'h09, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_count got=%h want=00", v); end
    endtask

    task automatic test_sync_read();
        logic [7:0] v;
        input_c = 2'b10;
        repeat (3) tick();
        rd(8'h03, v);
        checks++; if (v !== 8'h02) begin failures++; $display("FAIL sync_read_c got=%h want=02", v); end
        input_a = 2'b01;
        repeat (3) tick();
        rd(8'h01, v);
        checks++; if (v !== 8'h01) begin failures++; $display("FAIL sync_read_a got=%h want=01", v); end
        checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL irq_gated_by_en got=%b want=0", interrupt); end
    endtask

    task automatic test_out_write();
        logic [7:0] v;
        wr(8'h05, 8'hA5);
        checks++; if (out !== 8'hA5) begin failures++; $display("FAIL out_write got=%h want=a5", out); end
        wr(8'h15, 8'h3C);
        checks++; if (out !== 8'hA5) begin failures++; $display("FAIL out_unmapped got=%h want=a5", out); end
        rd(8'h05, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL read_unmapped got=%h want=00", v); end
    endtask

    task automatic test_fifo_overflow();
        logic [7:0] v;
        tx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(8'(k * 17));
            wr(8'h06, 8'(k * 17));
        end
        rd(8'h09, v);
        checks++; if (v !== 8'h04) begin failures++; $display("FAIL ovf_count got=%h want=04", v); end
        rd(8'h07, v);
        checks++; if (v !== 8'h06) begin failures++; $display("FAIL ovf_status got=%h want=06", v); end
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin
                failures++; $display("FAIL ovf_drain valid=%b data=%h want data=%h", tx_valid, tx_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            tick();
        end
        checks++; if (tx_valid !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL ovf_drain_end valid=%b left=%0d want 0", tx_valid, exp_q.size()); end
        tx_ready = 1'b0;
        wr(8'h07, 8'h04);
        rd(8'h07, v);
        checks++; if (v !== 8'h01) begin failures++; $display("FAIL ovf_clear got=%h want=01", v); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] v;
        tx_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            exp_q.push_back(8'hA1 + 8'(k));
            wr(8'h06, 8'hA1 + 8'(k));
        end
        tx_ready = 1'b1; port_id = 8'h06; out_port = 8'h66; write_strobe = 1'b1;
        checks++; if (tx_data !== exp_q[0]) begin failures++; $display("FAIL fpp_head got=%h want=%h", tx_data, exp_q[0]); end
        void'(exp_q.pop_front());
        exp_q.push_back(8'h66);
        tick();
        write_strobe = 1'b0; tx_ready = 1'b0; port_id = 8'h00;
        rd(8'h09, v);
        checks++; if (v !== 8'h04) begin failures++; $display("FAIL fpp_count got=%h want=04", v); end
        rd(8'h07, v);
        checks++; if (v !== 8'h02) begin failures++; $display("FAIL fpp_status got=%h want=02", v); end
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin
                failures++; $display("FAIL fpp_drain valid=%b data=%h want data=%h", tx_valid, tx_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            tick();
        end
        checks++; if (tx_valid !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL fpp_drain_end valid=%b left=%0d want 0", tx_valid, exp_q.size()); end
        tx_ready = 1'b0;
    endtask

    task automatic test_irq();
        logic [7:0] v;
        wr(8'h08, 8'h01);
        rd(8'h08, v);
        checks++; if (v !== 8'h01) begin failures++; $display("FAIL irq_en_read got=%h want=01", v); end
        checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL irq_idle got=%b want=0", interrupt); end
        input_a = ~input_a;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (interrupt === 1'b1) break;
        end
        checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL irq_on_change got=%b want=1", interrupt); end
        input_b = ~input_b;
        tick(); tick();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL irq_set_wins got=%b want=1", interrupt); end
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL irq_ack got=%b want=0", interrupt); end
        input_c = ~input_c;
        repeat (3) tick();
        checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL irq_c_change got=%b want=1", interrupt); end
        wr(8'h08, 8'h00);
        checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL irq_en_clear_keeps got=%b want=1", interrupt); end
        rd(8'h07, v);
        checks++; if (v !== 8'h09) begin failures++; $display("FAIL irq_status got=%h want=09", v); end
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        input_d = ~input_d;
        repeat (4) tick();
        checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL irq_disabled got=%b want=0", interrupt); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        wr(8'h08, 8'h01);
        tx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(8'hC0 + 8'(k));
            wr(8'h06, 8'hC0 + 8'(k));
        end
        input_a = ~input_a;
        repeat (3) tick();
        checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL rm_irq_before got=%b want=1", interrupt); end
        wr(8'h05, 8'h5A);
        port_id = 8'h07;
        tick();
        checks++; if (in_port !== 8'h08) begin failures++; $display("FAIL rm_status_before got=%h want=08", in_port); end
        #1 rst = 1'b0;
        #1;
        checks++; if (out !== 8'h00) begin failures++; $display("FAIL rm_out got=%h want=00", out); end
        checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL rm_in_port got=%h want=00", in_port); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rm_tx_valid got=%b want=0", tx_valid); end
        checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL rm_interrupt got=%b want=0", interrupt); end
        exp_q.delete();
        tick();
        rst = 1'b1;
        rd(8'h07, v);
        checks++; if (v !== 8'h01) begin failures++; $display("FAIL rm_status_after got=%h want=01", v); end
        wr(8'h08, 8'h01);
        tick();
        checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL rm_zero_history got=%b want=1", interrupt); end
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sync_read();
        test_out_write();
        test_fifo_overflow();
        test_full_push_pop();
        test_irq();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
